// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - opcodes, FSM states and op-legality helper for alu_sequencer
// Legality of op 12 depends on ALU_SEQ_MUL_EN.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_LOAD = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
        return op <= OP_MUL;
`else
        return op <= OP_LOAD;
`endif
    endfunction

endpackage

// File: rtl/alu_seq_step.sv
// rtl/alu_seq_step.sv - combinational single-step ALU/shift function, one EXEC cycle's worth
// MUL partial-product port exists only when ALU_SEQ_MUL_EN is defined.
module alu_seq_step
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
`ifdef ALU_SEQ_MUL_EN
    input  logic [WIDTH-1:0] mul_hi_i,
    output logic [WIDTH-1:0] mul_hi_o,
`endif
    output logic [WIDTH-1:0] acc_o,
    output logic             c_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum   = '0;
        acc_o = acc_i;
        c_o   = c_i;
`ifdef ALU_SEQ_MUL_EN
        mul_hi_o = mul_hi_i;
`endif
        case (op_i)
            OP_ADD: begin
                sum          = {1'b0, acc_i} + {1'b0, b_i};
                {c_o, acc_o} = sum;
            end
            OP_ADC: begin
                sum          = {1'b0, acc_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
                {c_o, acc_o} = sum;
            end
            OP_SUB: begin
                sum          = {1'b0, acc_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                {c_o, acc_o} = sum;
            end
            OP_INC: begin
                sum          = {1'b0, acc_i} + {{WIDTH{1'b0}}, 1'b1};
                {c_o, acc_o} = sum;
            end
            OP_DEC: begin
                sum          = {1'b0, acc_i} + {1'b0, {WIDTH{1'b1}}};
                {c_o, acc_o} = sum;
            end
            OP_AND: begin acc_o = acc_i & b_i; c_o = 1'b0; end
            OP_OR:  begin acc_o = acc_i | b_i; c_o = 1'b0; end
            OP_XOR: begin acc_o = acc_i ^ b_i; c_o = 1'b0; end
            OP_NOT: begin acc_o = ~acc_i;      c_o = 1'b0; end
            OP_SHL: begin
                acc_o = {acc_i[WIDTH-2:0], 1'b0};
                c_o   = acc_i[WIDTH-1];
            end
            OP_SHR: begin
                acc_o = {1'b0, acc_i[WIDTH-1:1]};
                c_o   = acc_i[0];
            end
            OP_LOAD: acc_o = b_i;
`ifdef ALU_SEQ_MUL_EN
            // acc doubles as the multiplier/low-product shift register; hi holds the upper half
            OP_MUL: begin
                sum      = {1'b0, mul_hi_i} + (acc_i[0] ? {1'b0, b_i} : '0);
                mul_hi_o = sum[WIDTH:1];
                acc_o    = {sum[0], acc_i[WIDTH-1:1]};
                c_o      = |sum[WIDTH:1];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer driving alu_seq_step over multi-cycle ops
// Define ALU_SEQ_MUL_EN to enable the shift-add multiply on op 12.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_b,
    input  logic [AMT_W-1:0] req_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_c,
    output logic             rsp_z,
    output logic             rsp_err
);

    localparam int MAX_SHIFT = (2 ** AMT_W) - 1;
    localparam int MAX_CNT   = (WIDTH > MAX_SHIFT) ? WIDTH : MAX_SHIFT;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             err_q, err_d;
    logic             hold_q, hold_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] step_acc;
    logic             step_c;
    logic             is_shift;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mul_hi_q, mul_hi_d, step_hi;
`endif

    alu_seq_step #(.WIDTH(WIDTH)) u_step (
        .op_i     (op_q),
        .acc_i    (acc_q),
        .b_i      (b_q),
        .c_i      (c_q),
`ifdef ALU_SEQ_MUL_EN
        .mul_hi_i (mul_hi_q),
        .mul_hi_o (step_hi),
`endif
        .acc_o    (step_acc),
        .c_o      (step_c)
    );

    assign is_shift  = (req_op == OP_SHL) || (req_op == OP_SHR);
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_acc   = acc_q;
    assign rsp_c     = c_q;
    assign rsp_z     = (acc_q == '0);
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        c_d     = c_q;
        err_d   = err_q;
        hold_d  = hold_q;
        op_d    = op_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef ALU_SEQ_MUL_EN
        mul_hi_d = mul_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    b_d     = req_b;
                    err_d   = !op_legal(req_op);
                    // illegal ops and zero-length shifts burn one EXEC cycle without touching acc/c
                    hold_d  = !op_legal(req_op) || (is_shift && (req_amt == '0));
                    cnt_d   = CNT_W'(1);
                    if (is_shift && (req_amt != '0)) begin
                        cnt_d = CNT_W'(req_amt);
                    end
`ifdef ALU_SEQ_MUL_EN
                    if (req_op == OP_MUL) begin
                        cnt_d = CNT_W'(WIDTH);
                    end
                    mul_hi_d = '0;
`endif
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!hold_q) begin
                    acc_d = step_acc;
                    c_d   = step_c;
`ifdef ALU_SEQ_MUL_EN
                    mul_hi_d = step_hi;
`endif
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            op_q    <= OP_ADD;
            b_q     <= '0;
            cnt_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
            mul_hi_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
            mul_hi_q <= mul_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer; MUL expectations follow ALU_SEQ_MUL_EN
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [3:0] req_b;
    logic [1:0] req_amt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_acc;
    logic       rsp_c;
    logic       rsp_z;
    logic       rsp_err;

    typedef struct {
        logic [3:0] acc;
        logic       c;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [3:0] m_acc;
    logic       m_c;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(4), .AMT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_b     (req_b),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_acc   (rsp_acc),
        .rsp_c     (rsp_c),
        .rsp_z     (rsp_z),
        .rsp_err   (rsp_err)
    );

    task automatic model_push(input logic [3:0] op, input logic [3:0] b, input logic [1:0] amt);
        exp_t e;
        int   s;
        e.err = 1'b0;
        e.cyc = 1;
        case (op)
            4'd0:  begin s = int'(m_acc) + int'(b);            m_acc = s[3:0]; m_c = (s > 15); end
            4'd1:  begin s = int'(m_acc) + int'(b) + int'(m_c); m_acc = s[3:0]; m_c = (s > 15); end
            4'd2:  begin s = int'(m_acc) + 16 - int'(b);       m_acc = s[3:0]; m_c = (s > 15); end
            4'd3:  begin s = int'(m_acc) + 1;                  m_acc = s[3:0]; m_c = (s > 15); end
            4'd4:  begin s = int'(m_acc) + 15;                 m_acc = s[3:0]; m_c = (s > 15); end
            4'd5:  begin m_acc = m_acc & b; m_c = 1'b0; end
            4'd6:  begin m_acc = m_acc | b; m_c = 1'b0; end
            4'd7:  begin m_acc = m_acc ^ b; m_c = 1'b0; end
            4'd8:  begin m_acc = ~m_acc;    m_c = 1'b0; end
            4'd9: begin
                if (amt != 2'd0) begin
                    m_c   = m_acc[4 - int'(amt)];
                    m_acc = m_acc << amt;
                    e.cyc = int'(amt);
                end
            end
            4'd10: begin
                if (amt != 2'd0) begin
                    m_c   = m_acc[int'(amt) - 1];
                    m_acc = m_acc >> amt;
                    e.cyc = int'(amt);
                end
            end
            4'd11: m_acc = b;
`ifdef ALU_SEQ_MUL_EN
            4'd12: begin s = int'(m_acc) * int'(b); m_acc = s[3:0]; m_c = (s > 15); e.cyc = 4; end
`endif
            default: e.err = 1'b1;
        endcase
        e.acc = m_acc;
        e.c   = m_c;
        sb.push_back(e);
    endtask

    // entered and left at posedge+1
    task automatic send(input logic [3:0] op, input logic [3:0] b, input logic [1:0] amt);
        int t = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_b     = b;
        req_amt   = amt;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        exp_t e;
        int   cyc = 0;
        e = sb.pop_front();
        @(negedge clk);
        while (!rsp_valid && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        compared += 6;
        if (cyc !== e.cyc) begin
            mismatched++;
            $display("FAIL %s exec_cycles: got %0d required %0d", name, cyc, e.cyc);
        end
        if (rsp_acc !== e.acc) begin
            mismatched++;
            $display("FAIL %s rsp_acc: got %h required %h", name, rsp_acc, e.acc);
        end
        if (rsp_c !== e.c) begin
            mismatched++;
            $display("FAIL %s rsp_c: got %b required %b", name, rsp_c, e.c);
        end
        if (rsp_z !== (e.acc == 4'h0)) begin
            mismatched++;
            $display("FAIL %s rsp_z: got %b required %b", name, rsp_z, (e.acc == 4'h0));
        end
        if (rsp_err !== e.err) begin
            mismatched++;
            $display("FAIL %s rsp_err: got %b required %b", name, rsp_err, e.err);
        end
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL %s req_ready_in_resp: got %b required 0", name, req_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [3:0] b,
                         input logic [1:0] amt);
        model_push(op, b, amt);
        send(op, b, amt);
        collect(name);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_b     = 4'h0;
        req_amt   = 2'd0;
        rsp_ready = 1'b0;
        m_acc     = 4'h0;
        m_c       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared += 6;
        if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset req_ready: got %b required 1", req_ready); end
        if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset rsp_valid: got %b required 0", rsp_valid); end
        if (rsp_acc !== 4'h0)   begin mismatched++; $display("FAIL reset rsp_acc: got %h required 0", rsp_acc); end
        if (rsp_c !== 1'b0)     begin mismatched++; $display("FAIL reset rsp_c: got %b required 0", rsp_c); end
        if (rsp_z !== 1'b1)     begin mismatched++; $display("FAIL reset rsp_z: got %b required 1", rsp_z); end
        if (rsp_err !== 1'b0)   begin mismatched++; $display("FAIL reset rsp_err: got %b required 0", rsp_err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        do_op("load9", 4'd11, 4'h9, 2'd0);
        do_op("add8", 4'd0, 4'h8, 2'd0);
    endtask

    task automatic test_sub_adc();
        do_op("load3", 4'd11, 4'h3, 2'd0);
        do_op("sub5", 4'd2, 4'h5, 2'd0);
        do_op("adc1", 4'd1, 4'h1, 2'd0);
    endtask

    task automatic test_shift();
        do_op("loadB", 4'd11, 4'hB, 2'd0);
        do_op("shl3", 4'd9, 4'h0, 2'd3);
        do_op("shl0", 4'd9, 4'h0, 2'd0);
        do_op("load6", 4'd11, 4'h6, 2'd0);
        do_op("shr2", 4'd10, 4'h0, 2'd2);
        do_op("shr0", 4'd10, 4'h0, 2'd0);
    endtask

    task automatic test_mul();
        do_op("load5", 4'd11, 4'h5, 2'd0);
        do_op("mul3", 4'd12, 4'h3, 2'd0);
        do_op("loadF", 4'd11, 4'hF, 2'd0);
        do_op("mulF", 4'd12, 4'hF, 2'd0);
    endtask

    task automatic test_illegal();
        do_op("load7", 4'd11, 4'h7, 2'd0);
        do_op("inc", 4'd3, 4'h0, 2'd0);
        do_op("op13", 4'd13, 4'h2, 2'd0);
        do_op("op15", 4'd15, 4'h9, 2'd3);
        do_op("xor3", 4'd7, 4'h3, 2'd0);
    endtask

    task automatic test_back_to_back();
        do_op("b2b_dec", 4'd4, 4'h0, 2'd0);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b idle_after_handshake: req_ready=%b required 1", req_ready);
        end
        do_op("b2b_not", 4'd8, 4'h0, 2'd0);
        do_op("b2b_or", 4'd6, 4'h5, 2'd0);
        do_op("b2b_and", 4'd5, 4'hC, 2'd0);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   t = 0;
        model_push(4'd7, 4'h5, 2'd0);
        send(4'd7, 4'h5, 2'd0);
        e = sb.pop_front();
        @(negedge clk);
        while (!rsp_valid && t < 50) begin
            t++;
            @(negedge clk);
        end
        req_valid = 1'b1;
        req_op    = 4'd11;
        req_b     = 4'h0;
        for (int i = 0; i < 5; i++) begin
            compared += 5;
            if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL stall%0d rsp_valid: got %b required 1", i, rsp_valid); end
            if (rsp_acc !== e.acc)  begin mismatched++; $display("FAIL stall%0d rsp_acc: got %h required %h", i, rsp_acc, e.acc); end
            if (rsp_c !== e.c)      begin mismatched++; $display("FAIL stall%0d rsp_c: got %b required %b", i, rsp_c, e.c); end
            if (rsp_err !== e.err)  begin mismatched++; $display("FAIL stall%0d rsp_err: got %b required %b", i, rsp_err, e.err); end
            if (req_ready !== 1'b0) begin mismatched++; $display("FAIL stall%0d req_ready: got %b required 0", i, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        compared += 2;
        if (rsp_acc !== m_acc) begin mismatched++; $display("FAIL stall_ignored_req rsp_acc: got %h required %h", rsp_acc, m_acc); end
        if (req_ready !== 1'b1) begin mismatched++; $display("FAIL stall_release req_ready: got %b required 1", req_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        do_op("rst_loadB", 4'd11, 4'hB, 2'd0);
        send(4'd9, 4'h0, 2'd3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared += 4;
        if (rsp_acc !== 4'h0)   begin mismatched++; $display("FAIL midreset rsp_acc: got %h required 0", rsp_acc); end
        if (rsp_c !== 1'b0)     begin mismatched++; $display("FAIL midreset rsp_c: got %b required 0", rsp_c); end
        if (req_ready !== 1'b1) begin mismatched++; $display("FAIL midreset req_ready: got %b required 1", req_ready); end
        if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL midreset rsp_valid: got %b required 0", rsp_valid); end
        m_acc = 4'h0;
        m_c   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            compared++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL postreset%0d: rsp_valid=%b req_ready=%b required 0/1", i, rsp_valid, req_ready);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_adc();
        test_shift();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
